// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: synchronises the SPI pins into clk, deserialises a
// command byte plus up to 8 data bytes, and shifts the register block's response onto MISO.
module spi_slave_if #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_ssel_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [7:0]  spi_cmd,
    output logic [63:0] spi_rxdata,
    output logic        spi_msg_end,
    input  logic [63:0] spi_txdata,
    input  logic        spi_txdata_valid
);

    localparam int unsigned SS       = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned BYTE_MAX = 9;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_start;
    logic           w_end;

    logic [SS-1:0]  r_ssel_sync;
    logic [SS-1:0]  r_sclk_sync;
    logic [SS-1:0]  r_mosi_sync;
    logic [SS-1:0]  r_settle;
    logic           r_sclk_d;
    logic [2:0]     r_bit_cnt;
    logic [3:0]     r_byte_cnt;
    logic [6:0]     r_rx_sr;
    logic [63:0]    r_tx_sr;
    logic [1:0]     r_load_p;

    logic           w_ssel_s;
    logic           w_sclk_s;
    logic           w_mosi_s;
    logic           w_shift_en;
    logic           w_rx_rise;
    logic           w_tx_fall;
    logic           w_byte_done;
    logic [7:0]     w_rx_byte;

    assign w_ssel_s    = r_ssel_sync[SS-1];
    assign w_sclk_s    = r_sclk_sync[SS-1];
    assign w_mosi_s    = r_mosi_sync[SS-1];
    // A deselect seen in the same clk as an SCLK edge takes priority over the edge.
    assign w_shift_en  = (r_state == ST_ACTIVE) && !w_ssel_s;
    assign w_rx_rise   = w_shift_en && w_sclk_s && !r_sclk_d;
    assign w_tx_fall   = w_shift_en && !w_sclk_s && r_sclk_d && (r_byte_cnt != 4'd0);
    assign w_rx_byte   = {r_rx_sr, w_mosi_s};
    assign w_byte_done = w_rx_rise && (r_bit_cnt == 3'd7);

    // Input synchronisers; r_settle marks when the chains hold real pin values after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ssel_sync <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_settle    <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_ssel_sync <= {r_ssel_sync[SS-2:0], spi_ssel_n};
            r_sclk_sync <= {r_sclk_sync[SS-2:0], spi_sclk};
            r_mosi_sync <= {r_mosi_sync[SS-2:0], spi_mosi};
            r_settle    <= {r_settle[SS-2:0], 1'b1};
            r_sclk_d    <= w_sclk_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ST_WAIT requires a genuine high on ssel_n before the first start after reset.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (r_settle[SS-1] && w_ssel_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!w_ssel_s) begin
                    w_state_nxt = ST_ACTIVE;
                    w_start     = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_ssel_s) begin
                    w_state_nxt = ST_IDLE;
                    w_end       = 1'b1;
                end
            end
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt   <= 3'd0;
            r_byte_cnt  <= 4'd0;
            r_rx_sr     <= 7'd0;
            r_tx_sr     <= 64'h0;
            r_load_p    <= 2'b00;
            spi_miso    <= 1'b0;
            spi_cmd     <= 8'h00;
            spi_rxdata  <= 64'h0;
            spi_msg_end <= 1'b0;
        end else begin
            spi_msg_end <= w_end && (r_byte_cnt != 4'd0);
            if (w_start) begin
                r_bit_cnt  <= 3'd0;
                r_byte_cnt <= 4'd0;
                r_rx_sr    <= 7'd0;
                r_tx_sr    <= 64'h0;
                r_load_p   <= 2'b00;
                spi_miso   <= 1'b0;
                spi_rxdata <= 64'h0;
            end else begin
                r_load_p <= {r_load_p[0], w_byte_done && (r_byte_cnt == 4'd0)};
                if (w_rx_rise) begin
                    r_rx_sr   <= w_rx_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (w_byte_done) begin
                    if (r_byte_cnt == 4'd0) begin
                        spi_cmd <= w_rx_byte;
                    end
                    for (int k = 1; k <= 8; k++) begin
                        if (r_byte_cnt == 4'(k)) begin
                            spi_rxdata[71-8*k -: 8] <= w_rx_byte;
                        end
                    end
                    if (r_byte_cnt != 4'(BYTE_MAX)) begin
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                    end
                end
                // Response is captured two clks after the command lands, giving the decoder a cycle.
                if (r_load_p[1]) begin
                    r_tx_sr <= spi_txdata_valid ? spi_txdata : 64'h0;
                end else if (w_tx_fall) begin
                    spi_miso <= r_tx_sr[63];
                    r_tx_sr  <= {r_tx_sr[62:0], 1'b0};
                end
            end
        end
    end

endmodule
